pre_if_pcgen: RTL and testbench

- Pre-IF next-PC generator sitting directly upstream of the branch target buffer (BTB) and the IF stage.
- Drives the BTB lookup port (`fetch_pc`/`fetch_en`) and consumes the BTB result one cycle later to pick the next PC: redirect target, predicted target, or PC+4.
- Presents each fetched PC plus its prediction tag to IF over a valid/allowin handshake, sustaining one PC per cycle.

---
 rtl/pre_if_pcgen.sv | 126 ++++++++++++
 tb/tb_pre_if_pcgen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pre_if_pcgen.sv
// pre_if_pcgen: next-PC generator that sits in front of the BTB and the IF stage.
//
// Each cycle it works out the next fetch address (fetch_pc) and strobes the BTB
// with it (fetch_en). One cycle later it uses the BTB result, the exception
// flush and the ID branch correction to choose the address after that. The
// current PC and its prediction tags go to IF over a valid/allowin handshake.
//
// Ports:
//   clk, resetn          clock, asynchronous active-low reset
//   fetch_pc, fetch_en   BTB lookup address and strobe
//   btb_ret_*            BTB result for the PC looked up on the last fetch_en
//   ex_flush, ex_target  exception/ertn redirect (highest priority)
//   id_redirect, id_target  branch-correction redirect from ID
//   fs_allowin           IF can accept a PC this cycle
//   fs_valid, fs_pc      PC handed to IF
//   fs_pred_*            prediction tags for fs_pc
//   fs_adef              fs_pc is not word aligned
module pre_if_pcgen #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          IDX_W    = 5
) (
    input  logic             clk,
    input  logic             resetn,
    output logic [31:0]      fetch_pc,
    output logic             fetch_en,
    input  logic             btb_ret_en,
    input  logic             btb_taken,
    input  logic [31:0]      btb_ret_pc,
    input  logic [IDX_W-1:0] btb_ret_index,
    input  logic             ex_flush,
    input  logic [31:0]      ex_target,
    input  logic             id_redirect,
    input  logic [31:0]      id_target,
    input  logic             fs_allowin,
    output logic             fs_valid,
    output logic [31:0]      fs_pc,
    output logic             fs_pred_hit,
    output logic             fs_pred_taken,
    output logic [31:0]      fs_pred_target,
    output logic [IDX_W-1:0] fs_pred_index,
    output logic             fs_adef
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state;
    logic [31:0] pc_r;
    logic        valid_r;
    logic        transfer;

    // Output side and next-PC selection
    always_comb begin
        // A redirect squashes the PC currently on offer to IF.
        fs_valid       = (state == RUN) & valid_r & ~ex_flush & ~id_redirect;
        fs_pc          = pc_r;
        // Prediction tags are qualified by fs_valid so that they read as zero
        // whenever no PC is on offer (including during reset).
        fs_pred_hit    = fs_valid & btb_ret_en;
        fs_pred_taken  = fs_pred_hit & btb_taken;
        fs_pred_target = fs_pred_taken ? btb_ret_pc : 32'd0;
        fs_pred_index  = fs_pred_hit ? btb_ret_index : '0;
        fs_adef        = fs_valid & (pc_r[1:0] != 2'b00);
        transfer       = fs_valid & fs_allowin;

        if (ex_flush)
            fetch_pc = ex_target;
        else if (id_redirect)
            fetch_pc = id_target;
        else if (state == BOOT)
            fetch_pc = RESET_PC;
        else if (fs_pred_taken)
            fetch_pc = btb_ret_pc;
        else
            fetch_pc = pc_r + 32'd4;

        // A misaligned PC is handed over once, flagged, and fetching stops
        // there: the sequential address after it is never looked up.
        case (state)
            BOOT:    fetch_en = 1'b1;
            RUN:     fetch_en = ex_flush | id_redirect | (transfer & ~fs_adef) | ~valid_r;
            HALT:    fetch_en = ex_flush;
            default: fetch_en = 1'b0;
        endcase
        fetch_en = fetch_en & resetn;
    end

    // State, PC and valid registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= BOOT;
            pc_r    <= 32'd0;
            valid_r <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state   <= RUN;
                    pc_r    <= fetch_pc;
                    valid_r <= 1'b1;
                end
                RUN: begin
                    if (transfer && fs_adef) begin
                        state   <= HALT;
                        valid_r <= 1'b0;
                    end else if (fetch_en) begin
                        pc_r    <= fetch_pc;
                        valid_r <= 1'b1;
                    end
                end
                HALT: begin
                    // Only an exception flush restarts fetch; ID corrections
                    // are ignored here.
                    if (ex_flush) begin
                        state   <= RUN;
                        pc_r    <= ex_target;
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    state   <= BOOT;
                    valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pre_if_pcgen.sv
// Directed bench for pre_if_pcgen: a table of per-cycle inputs and expected
// outputs, followed by a hand-written reset-during-stall sequence.
module tb_pre_if_pcgen;

    localparam int IDX_W = 5;

    logic             clk;
    logic             resetn;
    logic [31:0]      fetch_pc;
    logic             fetch_en;
    logic             btb_ret_en;
    logic             btb_taken;
    logic [31:0]      btb_ret_pc;
    logic [IDX_W-1:0] btb_ret_index;
    logic             ex_flush;
    logic [31:0]      ex_target;
    logic             id_redirect;
    logic [31:0]      id_target;
    logic             fs_allowin;
    logic             fs_valid;
    logic [31:0]      fs_pc;
    logic             fs_pred_hit;
    logic             fs_pred_taken;
    logic [31:0]      fs_pred_target;
    logic [IDX_W-1:0] fs_pred_index;
    logic             fs_adef;

    pre_if_pcgen #(.RESET_PC(32'h1c000000), .IDX_W(IDX_W)) dut (
        .clk(clk), .resetn(resetn),
        .fetch_pc(fetch_pc), .fetch_en(fetch_en),
        .btb_ret_en(btb_ret_en), .btb_taken(btb_taken),
        .btb_ret_pc(btb_ret_pc), .btb_ret_index(btb_ret_index),
        .ex_flush(ex_flush), .ex_target(ex_target),
        .id_redirect(id_redirect), .id_target(id_target),
        .fs_allowin(fs_allowin), .fs_valid(fs_valid), .fs_pc(fs_pc),
        .fs_pred_hit(fs_pred_hit), .fs_pred_taken(fs_pred_taken),
        .fs_pred_target(fs_pred_target), .fs_pred_index(fs_pred_index),
        .fs_adef(fs_adef)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        al, ef, ir, be, bt;
        logic [31:0] et, it, bp;
        logic [4:0]  bi;
        logic [31:0] e_fpc;
        logic        e_fen, e_fv;
        logic [31:0] e_pc;
        logic        e_hit, e_tk;
        logic [31:0] e_tgt;
        logic [4:0]  e_idx;
        logic        e_adef;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic al, input logic ef, input logic [31:0] et,
                       input logic ir, input logic [31:0] it,
                       input logic be, input logic bt, input logic [31:0] bp, input logic [4:0] bi,
                       input logic [31:0] e_fpc, input logic e_fen, input logic e_fv,
                       input logic [31:0] e_pc, input logic e_hit, input logic e_tk,
                       input logic [31:0] e_tgt, input logic [4:0] e_idx, input logic e_adef);
        vec_t v;
        v.al = al; v.ef = ef; v.et = et; v.ir = ir; v.it = it;
        v.be = be; v.bt = bt; v.bp = bp; v.bi = bi;
        v.e_fpc = e_fpc; v.e_fen = e_fen; v.e_fv = e_fv; v.e_pc = e_pc;
        v.e_hit = e_hit; v.e_tk = e_tk; v.e_tgt = e_tgt; v.e_idx = e_idx; v.e_adef = e_adef;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_fs_zero(input string tag);
        chk({tag, " fs_valid"}, 32'(fs_valid), 32'd0);
        chk({tag, " fs_pc"}, fs_pc, 32'd0);
        chk({tag, " fs_pred_hit"}, 32'(fs_pred_hit), 32'd0);
        chk({tag, " fs_pred_taken"}, 32'(fs_pred_taken), 32'd0);
        chk({tag, " fs_pred_target"}, fs_pred_target, 32'd0);
        chk({tag, " fs_pred_index"}, 32'(fs_pred_index), 32'd0);
        chk({tag, " fs_adef"}, 32'(fs_adef), 32'd0);
        chk({tag, " fetch_en"}, 32'(fetch_en), 32'd0);
    endtask

    task automatic drive_idle();
        fs_allowin = 1'b1; ex_flush = 1'b0; ex_target = 32'd0;
        id_redirect = 1'b0; id_target = 32'd0;
        btb_ret_en = 1'b0; btb_taken = 1'b0; btb_ret_pc = 32'd0; btb_ret_index = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //   al ef et            ir it            be bt bp            bi   fetch_pc      fen fv fs_pc         hit tk tgt           idx adef
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c000000, 1, 0, 32'h0,        0, 0, 32'h0,        0, 0); // boot
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c000004, 1, 1, 32'h1c000000, 0, 0, 32'h0,        0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c000008, 1, 1, 32'h1c000004, 0, 0, 32'h0,        0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        1, 1, 32'h1c000100, 3,  32'h1c000100, 1, 1, 32'h1c000008, 1, 1, 32'h1c000100, 3, 0); // taken hit
        add(1, 0, 32'h0,        1, 32'h1c000008, 0, 0, 32'h0,        0,  32'h1c000008, 1, 0, 32'h1c000100, 0, 0, 32'h0,        0, 0); // id back
        add(1, 0, 32'h0,        0, 32'h0,        1, 0, 32'h1c000100, 3,  32'h1c00000c, 1, 1, 32'h1c000008, 1, 0, 32'h0,        3, 0); // not-taken hit
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c000010, 1, 1, 32'h1c00000c, 0, 0, 32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c000014, 0, 1, 32'h1c000010, 0, 0, 32'h0,        0, 0); // stall x3
        add(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c000014, 0, 1, 32'h1c000010, 0, 0, 32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c000014, 0, 1, 32'h1c000010, 0, 0, 32'h0,        0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c000014, 1, 1, 32'h1c000010, 0, 0, 32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c000018, 0, 1, 32'h1c000014, 0, 0, 32'h0,        0, 0); // stall
        add(0, 1, 32'h1c008000, 1, 32'h1c000200, 0, 0, 32'h0,        0,  32'h1c008000, 1, 0, 32'h1c000014, 0, 0, 32'h0,        0, 0); // both redirects
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c008004, 1, 1, 32'h1c008000, 0, 0, 32'h0,        0, 0);
        add(1, 0, 32'h0,        1, 32'h1c000202, 0, 0, 32'h0,        0,  32'h1c000202, 1, 0, 32'h1c008004, 0, 0, 32'h0,        0, 0); // misaligned target
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c000206, 0, 1, 32'h1c000202, 0, 0, 32'h0,        0, 1); // adef transfer
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c000206, 0, 0, 32'h1c000202, 0, 0, 32'h0,        0, 0); // halt
        add(1, 0, 32'h0,        1, 32'h1c000300, 0, 0, 32'h0,        0,  32'h1c000300, 0, 0, 32'h1c000202, 0, 0, 32'h0,        0, 0); // id ignored
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c000206, 0, 0, 32'h1c000202, 0, 0, 32'h0,        0, 0);
        add(1, 1, 32'h1c008000, 0, 32'h0,        0, 0, 32'h0,        0,  32'h1c008000, 1, 0, 32'h1c000202, 0, 0, 32'h0,        0, 0); // flush leaves halt
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h1c008004, 1, 1, 32'h1c008000, 0, 0, 32'h0,        0, 0);
        add(1, 0, 32'h0,        1, 32'hfffffffc, 0, 0, 32'h0,        0,  32'hfffffffc, 1, 0, 32'h1c008004, 0, 0, 32'h0,        0, 0);
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h00000000, 1, 1, 32'hfffffffc, 0, 0, 32'h0,        0, 0); // wrap
        add(1, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0,  32'h00000004, 1, 1, 32'h00000000, 0, 0, 32'h0,        0, 0);
        add(0, 0, 32'h0,        0, 32'h0,        1, 1, 32'h1c000040, 7,  32'h1c000040, 0, 1, 32'h00000004, 1, 1, 32'h1c000040, 7, 0); // stall on hit

        drive_idle();
        resetn = 1'b0;
        #3;
        chk_fs_zero("reset");

        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            fs_allowin = vecs[i].al;
            ex_flush = vecs[i].ef; ex_target = vecs[i].et;
            id_redirect = vecs[i].ir; id_target = vecs[i].it;
            btb_ret_en = vecs[i].be; btb_taken = vecs[i].bt;
            btb_ret_pc = vecs[i].bp; btb_ret_index = vecs[i].bi;
            #1;
            chk($sformatf("v%0d fetch_pc", i), fetch_pc, vecs[i].e_fpc);
            chk($sformatf("v%0d fetch_en", i), 32'(fetch_en), 32'(vecs[i].e_fen));
            chk($sformatf("v%0d fs_valid", i), 32'(fs_valid), 32'(vecs[i].e_fv));
            chk($sformatf("v%0d fs_pc", i), fs_pc, vecs[i].e_pc);
            chk($sformatf("v%0d fs_pred_hit", i), 32'(fs_pred_hit), 32'(vecs[i].e_hit));
            chk($sformatf("v%0d fs_pred_taken", i), 32'(fs_pred_taken), 32'(vecs[i].e_tk));
            chk($sformatf("v%0d fs_pred_target", i), fs_pred_target, vecs[i].e_tgt);
            chk($sformatf("v%0d fs_pred_index", i), 32'(fs_pred_index), 32'(vecs[i].e_idx));
            chk($sformatf("v%0d fs_adef", i), 32'(fs_adef), 32'(vecs[i].e_adef));
            @(negedge clk);
        end

        // Still stalled on PC 4 with a BTB hit: confirm the stall held, then
        // pulse reset mid-cycle and check outputs drop without a clock edge.
        #1;
        chk("stall hold fs_pc", fs_pc, 32'h4);
        chk("stall hold fs_pred_hit", 32'(fs_pred_hit), 32'd1);
        #1;
        resetn = 1'b0;
        #1;
        chk_fs_zero("async reset");
        @(negedge clk);
        @(negedge clk);
        drive_idle();
        resetn = 1'b1;
        #1;
        chk("after reset fetch_pc", fetch_pc, 32'h1c000000);
        chk("after reset fetch_en", 32'(fetch_en), 32'd1);
        chk("after reset fs_valid", 32'(fs_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("after reset first fs_valid", 32'(fs_valid), 32'd1);
        chk("after reset first fs_pc", fs_pc, 32'h1c000000);
        chk("after reset next fetch_pc", fetch_pc, 32'h1c000004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
